// File: rtl/multichannel_frac_delay_if.sv
// multichannel_frac_delay_if: sample and delay bus for the fractional delay line
// master drives: in_valid, frame_start, din, delay_int, delay_frac
// slave  drives: out_valid, dout, delay_err
interface multichannel_frac_delay_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int FRAC_WIDTH = 4
);
  logic                         in_valid;
  logic                         frame_start;
  logic [NUM_CH*DATA_WIDTH-1:0] din;
  logic [NUM_CH*ADDR_WIDTH-1:0] delay_int;
  logic [NUM_CH*FRAC_WIDTH-1:0] delay_frac;
  logic                         out_valid;
  logic [NUM_CH*DATA_WIDTH-1:0] dout;
  logic                         delay_err;
  modport master (
    output in_valid, frame_start, din, delay_int, delay_frac,
    input  out_valid, dout, delay_err
  );
  modport slave (
    input  in_valid, frame_start, din, delay_int, delay_frac,
    output out_valid, dout, delay_err
  );
endinterface

// File: rtl/multichannel_frac_delay.sv
// multichannel_frac_delay: per-channel fractional-sample delay line with linear interpolation
// clk   : clock, all logic on posedge
// reset : synchronous active-low reset
// bus   : slave side of multichannel_frac_delay_if (samples and delays in, delayed samples out)
module multichannel_frac_delay #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 4,
  parameter int MAX_DELAY  = 256,
  parameter int ADDR_WIDTH = $clog2(MAX_DELAY),
  parameter int FRAC_WIDTH = 4
) (
  input logic clk,
  input logic reset,
  multichannel_frac_delay_if.slave bus
);
  localparam int PW = DATA_WIDTH + FRAC_WIDTH + 2;
  localparam logic [ADDR_WIDTH-1:0] D_MAX = ADDR_WIDTH'(MAX_DELAY - 2);
  localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH + 1)'(MAX_DELAY);
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH:0]   fill_cnt;
  logic                  v1, out_valid, delay_err, latch;
  logic [NUM_CH-1:0]     clamp;
  assign latch         = bus.in_valid & bus.frame_start;
  assign bus.out_valid = out_valid;
  assign bus.delay_err = delay_err;
  always_ff @(posedge clk)
    if (!reset) begin
      wr_ptr    <= '0;
      fill_cnt  <= '0;
      v1        <= 1'b0;
      out_valid <= 1'b0;
      delay_err <= 1'b0;
    end else begin
      v1        <= bus.in_valid;
      out_valid <= v1;
      if (bus.in_valid) begin
        wr_ptr   <= wr_ptr + 1'b1;
        fill_cnt <= (fill_cnt == FULL) ? fill_cnt : fill_cnt + 1'b1;
      end
      if (latch) delay_err <= |clamp;
    end
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DATA_WIDTH-1:0] mem [MAX_DELAY];
    logic [DATA_WIDTH-1:0] x, a, b, a_r, b_r, y, dout_r;
    logic [ADDR_WIDTH-1:0] di, d_reg, d_act, d1;
    logic [FRAC_WIDTH-1:0] f_reg, f_act, f_r;
    logic signed [DATA_WIDTH:0] diff;
    logic signed [PW-1:0]       prod;
    assign x        = bus.din[c*DATA_WIDTH +: DATA_WIDTH];
    assign di       = bus.delay_int[c*ADDR_WIDTH +: ADDR_WIDTH];
    assign clamp[c] = di > D_MAX;
    // In the latch beat the new delays bypass the registers so that sample already uses them.
    // Taps older than the number of samples written since reset read as zero.
    always_comb begin
      d_act = latch ? (clamp[c] ? D_MAX : di) : d_reg;
      f_act = latch ? bus.delay_frac[c*FRAC_WIDTH +: FRAC_WIDTH] : f_reg;
      d1    = d_act + 1'b1;
      a     = (d_act == '0) ? x : (({1'b0, d_act} > fill_cnt) ? '0 : mem[wr_ptr - d_act]);
      b     = ({1'b0, d1} > fill_cnt) ? '0 : mem[wr_ptr - d1];
      diff  = $signed({b_r[DATA_WIDTH-1], b_r}) - $signed({a_r[DATA_WIDTH-1], a_r});
      prod  = PW'(diff) * PW'($signed({1'b0, f_r}));
      // y stays between a and b, so truncation back to DATA_WIDTH cannot overflow
      y     = DATA_WIDTH'(PW'($signed(a_r)) + (prod >>> FRAC_WIDTH));
    end
    always_ff @(posedge clk)
      if (reset && bus.in_valid) mem[wr_ptr] <= x;
    always_ff @(posedge clk)
      if (!reset) begin
        d_reg  <= '0;
        f_reg  <= '0;
        a_r    <= '0;
        b_r    <= '0;
        f_r    <= '0;
        dout_r <= '0;
      end else begin
        if (latch) begin
          d_reg <= d_act;
          f_reg <= f_act;
        end
        if (bus.in_valid) begin
          a_r <= a;
          b_r <= b;
          f_r <= f_act;
        end
        if (v1) dout_r <= y;
      end
    assign bus.dout[c*DATA_WIDTH +: DATA_WIDTH] = dout_r;
  end
endmodule

// File: tb/tb_multichannel_frac_delay.sv
// tb_multichannel_frac_delay: scoreboard bench for the fractional delay line
module tb_multichannel_frac_delay;
  localparam int DW = 16, NC = 4, AW = 8, FW = 4, MD = 256;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  multichannel_frac_delay_if #(.DATA_WIDTH(DW), .NUM_CH(NC), .ADDR_WIDTH(AW), .FRAC_WIDTH(FW)) bus ();
  multichannel_frac_delay #(.DATA_WIDTH(DW), .NUM_CH(NC), .MAX_DELAY(MD), .ADDR_WIDTH(AW), .FRAC_WIDTH(FW))
    dut (.clk(clk), .reset(reset), .bus(bus));
  int n_vec = 0, n_err = 0;
  logic [NC*DW-1:0] exp_q[$];
  logic [NC*DW-1:0] mon_e;
  int hist[NC][$];
  int md[NC], mf[NC];

  task automatic chk(input string name, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  function automatic int ch(input int k);
    logic [DW-1:0] v;
    v = bus.dout[k*DW +: DW];
    return int'($signed(v));
  endfunction

  function automatic int floor16(input int p);
    return (p - (((p % 16) + 16) % 16)) / 16;
  endfunction

  function automatic int tap(input int c, input int k, input int cur);
    if (k == 0) return cur;
    if (k > hist[c].size()) return 0;
    return hist[c][hist[c].size() - k];
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.frame_start = 1'b0;
    end
  endtask

  task automatic beat(input int x[NC], input bit fs, input int di[NC], input int df[NC]);
    logic [NC*DW-1:0] e;
    int a, b;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.frame_start = fs;
    for (int c = 0; c < NC; c++) begin
      bus.din[c*DW +: DW] = DW'(x[c]);
      bus.delay_int[c*AW +: AW] = AW'(di[c]);
      bus.delay_frac[c*FW +: FW] = FW'(df[c]);
      if (fs) begin
        md[c] = (di[c] > MD - 2) ? MD - 2 : di[c];
        mf[c] = df[c];
      end
      a = tap(c, md[c], x[c]);
      b = tap(c, md[c] + 1, x[c]);
      e[c*DW +: DW] = DW'(a + floor16((b - a) * mf[c]));
      hist[c].push_back(x[c]);
    end
    exp_q.push_back(e);
  endtask

  task automatic step(input int x[NC], input bit fs, input int di[NC], input int df[NC]);
    beat(x, fs, di, df);
    idle(2);
  endtask

  task automatic model_clear();
    exp_q.delete();
    for (int c = 0; c < NC; c++) begin
      hist[c].delete();
      md[c] = 0;
      mf[c] = 0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.frame_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    reset = 1'b1;
  endtask

  always @(negedge clk)
    if (reset && bus.out_valid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_out got=%h exp=none", bus.dout);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.dout !== mon_e) begin
          n_err++;
          $display("FAIL scoreboard got=%h exp=%h", bus.dout, mon_e);
        end
      end
    end

  initial begin
    #10_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int z[NC];
    z = '{0, 0, 0, 0};
    bus.in_valid = 1'b0;
    bus.frame_start = 1'b0;
    bus.din = '0;
    bus.delay_int = '0;
    bus.delay_frac = '0;
    do_reset();
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_dout", bus.dout, 0);
    chk("reset_delay_err", bus.delay_err, 0);

    // passthrough
    for (int n = 1; n <= 3; n++) begin
      step('{n, n, n, n}, n == 1, z, z);
      chk($sformatf("pass_ch0_%0d", n), ch(0), n);
      chk($sformatf("pass_ch3_%0d", n), ch(3), n);
    end

    // integer delay with fill masking
    do_reset();
    for (int n = 0; n < 5; n++) begin
      step('{n == 0 ? 100 : 0, 0, 0, 0}, n == 0, '{3, 0, 0, 0}, z);
      chk($sformatf("int_d3_s%0d", n), ch(0), n == 3 ? 100 : 0);
    end

    // fractional: ch1 +step, ch3 -step at half sample, ch2 floor of -1/16
    do_reset();
    for (int n = 0; n < 10; n++) begin
      step('{0, n >= 5 ? 1000 : 0, n == 0 ? 4 : 5, n >= 5 ? -1000 : 0}, n == 0,
           '{0, 2, 0, 2}, '{0, 8, 1, 8});
      if (n == 1) chk("frac_floor_ch2", ch(2), 4);
      if (n == 7) begin
        chk("frac_half_pos", ch(1), 500);
        chk("frac_half_neg", ch(3), -500);
      end
      if (n == 8) begin
        chk("frac_full_pos", ch(1), 1000);
        chk("frac_full_neg", ch(3), -1000);
      end
    end

    // frame latch: delay_int changes without frame_start are ignored
    do_reset();
    for (int n = 0; n <= 21; n++) begin
      step('{n*10, n*10 + 1, n*10 + 2, n*10 + 3}, n == 0 || n == 20,
           n == 0 ? '{1, 1, 1, 1} : '{5, 5, 5, 5}, z);
      if (n == 10) chk("latch_hold_s10", ch(0), 90);
      if (n == 19) chk("latch_hold_s19", ch(0), 180);
      if (n == 20) chk("latch_new_s20", ch(0), 150);
      if (n == 21) chk("latch_new_s21", ch(1), 161);
    end

    // clamp and pointer wrap with in_valid gaps
    do_reset();
    for (int n = 0; n < 600; n++) begin
      beat('{n*37, n*37 + 1000, n*37 + 2000, n*37 + 3000}, n == 0,
           '{255, 255, 255, 255}, '{0, 4, 0, 0});
      idle($urandom_range(0, 2));
    end
    idle(2);
    chk("clamp_err", bus.delay_err, 1);
    chk("wrap_ch0", ch(0), 12765);
    chk("wrap_ch1_frac", ch(1), 13755);
    step(z, 1'b1, z, z);
    chk("clamp_err_cleared", bus.delay_err, 0);

    // reset with two samples in flight
    do_reset();
    step('{7, 7, 7, 7}, 1'b1, z, z);
    chk("pre_reset_dout", ch(0), 7);
    beat('{8, 8, 8, 8}, 1'b0, z, z);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.din = {NC{16'sd9}};
    model_clear();
    @(posedge clk); #1;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_dout", bus.dout, 0);
    idle(3);
    for (int n = 0; n < 3; n++) begin
      step('{11 + n, 0, 0, 0}, n == 0, '{2, 0, 0, 0}, z);
      chk($sformatf("postrst_s%0d", n), ch(0), n == 2 ? 11 : 0);
    end

    idle(4);
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
